// File: rtl/arith_pkg.sv
// arith_pkg: shared state encoding and default width for the arithmetic unit
package arith_pkg;
    typedef enum logic [1:0] {READY_S, SHIFT_S, SUB_S, CHECK_S} div_state_t;
    localparam int DIV_W = 4;
endpackage

// File: rtl/divider_if.sv
// divider_if: start/ready request and result bundle between controller and divider
interface divider_if import arith_pkg::*; #(parameter int N = DIV_W);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         ready;
    logic         div_by_zero;
    modport master(output start, dividend, divisor, input quotient, remainder, ready, div_by_zero);
    modport slave(input start, dividend, divisor, output quotient, remainder, ready, div_by_zero);
endinterface

// File: rtl/divider_addsubn.sv
// addsubn: W-bit adder/subtractor, two's complement subtract when i_sub is high
module addsubn #(parameter int W = 5) (
    input  logic [W-1:0] i_op1,
    input  logic [W-1:0] i_op2,
    input  logic         i_sub,
    output logic [W-1:0] o_result
);
    assign o_result = i_op1 + (i_op2 ^ {W{i_sub}}) + W'(i_sub);
endmodule

// File: rtl/divider.sv
// divider: sequential unsigned restoring divider, one shift/subtract/check step per cycle
module divider import arith_pkg::*; #(parameter int N = DIV_W) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    div_state_t    r_state, w_next;
    logic [N:0]    r_a, w_sum;
    logic [N-1:0]  r_q, r_m;
    logic [CW-1:0] r_cnt;
    logic          r_dbz;
    logic          w_accept;
    assign w_accept        = r_state == READY_S && bus.start;
    assign bus.ready       = r_state == READY_S;
    assign bus.quotient    = r_q;
    assign bus.remainder   = r_a[N-1:0];
    assign bus.div_by_zero = r_dbz;
    // subtract in SUB_S, restoring add in CHECK_S
    addsubn #(.W(N + 1)) u_addsub (
        .i_op1(r_a),
        .i_op2({1'b0, r_m}),
        .i_sub(r_state == SUB_S),
        .o_result(w_sum)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= READY_S;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            READY_S: w_next = (bus.start && bus.divisor != '0) ? SHIFT_S : READY_S;
            SHIFT_S: w_next = SUB_S;
            SUB_S:   w_next = CHECK_S;
            CHECK_S: w_next = (r_cnt == CW'(N - 1)) ? READY_S : SHIFT_S;
            default: w_next = READY_S;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            if (bus.divisor != '0) begin
                r_a   <= '0;
                r_q   <= bus.dividend;
                r_m   <= bus.divisor;
                r_cnt <= '0;
                r_dbz <= 1'b0;
            end else begin
                r_a   <= {1'b0, bus.dividend};
                r_q   <= '1;
                r_dbz <= 1'b1;
            end
        end else if (r_state == SHIFT_S) begin
            {r_a, r_q} <= {r_a[N-1:0], r_q, 1'b0};
        end else if (r_state == SUB_S) begin
            r_a <= w_sum;
        end else if (r_state == CHECK_S) begin
            // negative partial remainder means the divisor did not fit
            r_a    <= r_a[N] ? w_sum : r_a;
            r_q[0] <= ~r_a[N];
            r_cnt  <= r_cnt + CW'(1);
        end
    end
endmodule
